// File: rtl/alu_seq.sv
// ALU stage feeding the zero-flag register: single-cycle PASSB/ADD/SUB/INC/AND
// and an iterative shift-add MUL taking WIDTH cycles with a busy indication.
module alu_seq #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic [WIDTH-1:0] result,
  output logic             zWrEn,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  typedef enum logic [2:0] {
    OP_PASSB = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_MUL   = 3'd3,
    OP_INC   = 3'd4,
    OP_AND   = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] mcand, mcandNext;
  logic [WIDTH-1:0] mplier, mplierNext;
  logic [WIDTH-1:0] acc, accNext;
  logic [CW-1:0]    cnt, cntNext;
  logic [WIDTH-1:0] resultNext;
  logic             zWrEnNext;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] accSum;

  assign busy = (state == MUL);

  always_comb begin
    stateNext  = state;
    mcandNext  = mcand;
    mplierNext = mplier;
    accNext    = acc;
    cntNext    = cnt;
    resultNext = result;
    zWrEnNext  = 1'b0;
    addend     = mplier[0] ? mcand : '0;
    accSum     = acc + addend;

    case (state)
      IDLE: begin
        if (start) begin
          case (op_t'(op))
            OP_PASSB: begin
              resultNext = bIn;
              zWrEnNext  = 1'b1;
            end
            OP_ADD: begin
              resultNext = aIn + bIn;
              zWrEnNext  = 1'b1;
            end
            OP_SUB: begin
              resultNext = aIn - bIn;
              zWrEnNext  = 1'b1;
            end
            OP_INC: begin
              resultNext = aIn + WIDTH'(1);
              zWrEnNext  = 1'b1;
            end
            OP_AND: begin
              resultNext = aIn & bIn;
              zWrEnNext  = 1'b1;
            end
            OP_MUL: begin
              mcandNext  = aIn;
              mplierNext = bIn;
              accNext    = '0;
              cntNext    = '0;
              stateNext  = MUL;
            end
            default: ;
          endcase
        end
      end

      MUL: begin
        accNext    = accSum;
        mcandNext  = mcand << 1;
        mplierNext = mplier >> 1;
        cntNext    = cnt + CW'(1);
        // Completion edge publishes the sum that includes this iteration's add.
        if (cnt == CW'(WIDTH - 1)) begin
          resultNext = accSum;
          zWrEnNext  = 1'b1;
          stateNext  = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zWrEn  <= 1'b0;
    end else begin
      state  <= stateNext;
      mcand  <= mcandNext;
      mplier <= mplierNext;
      acc    <= accNext;
      cnt    <= cntNext;
      result <= resultNext;
      zWrEn  <= zWrEnNext;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: expected results are queued when an op is
// driven and popped when the DUT signals completion with zWrEn.
module tb_alu_seq;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic [W-1:0] result;
  logic         zWrEn;
  logic         busy;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sbq[$];
  logic [W-1:0] lastRes;
  logic [W-1:0] exp;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .aIn    (aIn),
    .bIn    (bIn),
    .result (result),
    .zWrEn  (zWrEn),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // zWrEn must never coincide with busy.
  always @(negedge clk) begin
    if (zWrEn) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL zwr_busy_overlap: busy=%b required 0 at %0t", busy, $time);
      end
    end
  end

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    case (o)
      3'd0:    r = b;
      3'd1:    r = a + b;
      3'd2:    r = a - b;
      3'd3:    r = a * b;
      3'd4:    r = a + 1;
      3'd5:    r = a & b;
      default: r = lastRes;
    endcase
    return r;
  endfunction

  // Empty queue yields X so the following comparison cannot pass.
  function automatic logic [W-1:0] popExp();
    logic [W-1:0] v;
    if (sbq.size() == 0) return 'x;
    v = sbq.pop_front();
    lastRes = v;
    return v;
  endfunction

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic drive_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    aIn   = a;
    bIn   = b;
    if (o < 3'd6) sbq.push_back(model(o, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; aIn = '0; bIn = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lastRes = '0;
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 000", result); end
    checks++;
    if (zWrEn !== 1'b0) begin errors++; $display("FAIL reset_zwren: got %b want 0", zWrEn); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_add();
    drive_op(3'd1, 12'd5, 12'd7);
    exp = popExp();
    checks++;
    if (result !== exp || exp !== 12'd12) begin
      errors++; $display("FAIL add_result: got %h want %h", result, exp);
    end
    checks++;
    if (zWrEn !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL add_flags: zWrEn=%b busy=%b want 1 0", zWrEn, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (zWrEn !== 1'b0 || result !== exp) begin
      errors++; $display("FAIL add_pulse_end: zWrEn=%b result=%h want 0 %h", zWrEn, result, exp);
    end
  endtask

  task automatic test_sub();
    drive_op(3'd2, 12'd4, 12'd4);
    exp = popExp();
    checks++;
    if (result !== exp || zWrEn !== 1'b1) begin
      errors++; $display("FAIL sub_zero: result=%h zWrEn=%b want %h 1", result, zWrEn, exp);
    end
    @(posedge clk); #1;
    drive_op(3'd2, 12'd3, 12'd5);
    exp = popExp();
    checks++;
    if (result !== exp || exp !== 12'hFFE || zWrEn !== 1'b1) begin
      errors++; $display("FAIL sub_neg: result=%h zWrEn=%b want %h 1", result, zWrEn, exp);
    end
    @(posedge clk); #1;
  endtask

  // Runs a MUL; optionally injects an ignored ADD request mid-flight.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject,
                         input string name);
    int cycles;
    logic [W-1:0] old;
    old = lastRes;
    drive_op(3'd3, a, b);
    cycles = 0;
    while (!zWrEn && cycles < 3 * W) begin
      checks++;
      if (busy !== 1'b1 || result !== old) begin
        errors++;
        $display("FAIL %s_hold: busy=%b result=%h want 1 %h at iter %0d", name, busy, result, old, cycles);
      end
      if (inject && cycles == 3) begin
        start = 1'b1; op = 3'd1; aIn = 12'd1; bIn = 12'd1;
      end
      if (inject && cycles == 4) begin
        start = 1'b0; aIn = W'($urandom); bIn = W'($urandom); op = 3'd0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    checks++;
    if (cycles != W) begin
      errors++; $display("FAIL %s_latency: got %0d cycles want %0d", name, cycles, W);
    end
    exp = popExp();
    checks++;
    if (result !== exp || zWrEn !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: result=%h zWrEn=%b busy=%b want %h 1 0", name, result, zWrEn, busy, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (zWrEn !== 1'b0 || result !== exp) begin
      errors++; $display("FAIL %s_no_extra: zWrEn=%b result=%h want 0 %h", name, zWrEn, result, exp);
    end
  endtask

  task automatic test_mul();
    run_mul(12'd25, 12'd3, 1'b0, "mul75");
    checks++;
    if (lastRes !== 12'd75) begin errors++; $display("FAIL mul75_value: got %h want 04b", lastRes); end
    run_mul(12'h800, 12'd2, 1'b0, "mulwrap");
    run_mul(12'd37, 12'd41, 1'b1, "mulignore");
  endtask

  task automatic test_reset_mid_mul();
    bit pulsed;
    drive_op(3'd3, 12'd9, 12'd9);
    void'(sbq.pop_back());
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lastRes = '0;
    checks++;
    if (result !== '0 || busy !== 1'b0 || zWrEn !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_mul: result=%h busy=%b zWrEn=%b want 000 0 0", result, busy, zWrEn);
    end
    pulsed = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (zWrEn) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin errors++; $display("FAIL rst_no_pulse: zWrEn pulsed=1 want 0"); end
    drive_op(3'd4, 12'hFFF, 12'd0);
    exp = popExp();
    checks++;
    if (result !== exp || exp !== '0 || zWrEn !== 1'b1) begin
      errors++; $display("FAIL inc_wrap: result=%h zWrEn=%b want %h 1", result, zWrEn, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] prev;
    drive_op(3'd1, 12'd1, 12'd2);
    exp = popExp();
    checks++;
    if (result !== exp || zWrEn !== 1'b1) begin
      errors++; $display("FAIL b2b_first: result=%h zWrEn=%b want %h 1", result, zWrEn, exp);
    end
    drive_op(3'd5, 12'h0F0, 12'h03C);
    exp = popExp();
    checks++;
    if (result !== exp || exp !== 12'h030 || zWrEn !== 1'b1) begin
      errors++; $display("FAIL b2b_second: result=%h zWrEn=%b want %h 1", result, zWrEn, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (zWrEn !== 1'b0) begin errors++; $display("FAIL b2b_end: zWrEn=%b want 0", zWrEn); end
    prev = lastRes;
    drive_op(3'd6, 12'h123, 12'h456);
    checks++;
    if (result !== prev || zWrEn !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reserved6: result=%h zWrEn=%b busy=%b want %h 0 0", result, zWrEn, busy, prev);
    end
    drive_op(3'd0, 12'hABC, 12'h5A5);
    exp = popExp();
    checks++;
    if (result !== exp || zWrEn !== 1'b1) begin
      errors++; $display("FAIL passb: result=%h zWrEn=%b want %h 1", result, zWrEn, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
